// File: rtl/reset_sequence_ctrl.sv
// rtl/reset_sequence_ctrl.sv - staged reset release gated by PLL lock and EMIF calibration
// Optional feature macro: RESET_SEQ_AUTO_RETRY_EN (ERROR retries from HOLD after TIMEOUT_CYCLES)
module reset_sequence_ctrl #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_locked,
  input  logic                  cal_success,
  input  logic                  cal_fail,
  input  logic                  restart_req,
  output logic [NUM_STAGES-1:0] reset_out,
  output logic                  seq_done,
  output logic                  seq_error,
  output logic [2:0]            state_o
);

  localparam int MAX_CNT = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int KW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [KW-1:0] STAGE_LAST   = KW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    WAIT_CAL = 3'd1,
    RELEASE  = 3'd2,
    RUN      = 3'd3,
    ERROR    = 3'd4
  } state_t;

  state_t                state, state_n;
  logic                  sync1, locked_sync;
  logic [CW-1:0]         hold_cnt, hold_n;
  logic [CW-1:0]         timer, timer_n;
  logic [KW-1:0]         stage, stage_n;
  logic [NUM_STAGES-1:0] reset_next;
  logic                  done_next, err_next;
  logic                  go_error;

  assign state_o = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1       <= 1'b0;
      locked_sync <= 1'b0;
      state       <= HOLD;
      hold_cnt    <= '0;
      timer       <= '0;
      stage       <= '0;
      reset_out   <= '1;
      seq_done    <= 1'b0;
      seq_error   <= 1'b0;
    end else begin
      sync1       <= pll_locked;
      locked_sync <= sync1;
      state       <= state_n;
      hold_cnt    <= hold_n;
      timer       <= timer_n;
      stage       <= stage_n;
      reset_out   <= reset_next;
      seq_done    <= done_next;
      seq_error   <= err_next;
    end
  end

  always_comb begin
    state_n    = state;
    hold_n     = hold_cnt;
    timer_n    = timer;
    stage_n    = stage;
    reset_next = reset_out;
    done_next  = 1'b0;
    err_next   = 1'b0;
    go_error   = 1'b0;

    if (!locked_sync || restart_req) begin
      state_n    = HOLD;
      reset_next = '1;
      hold_n     = '0;
      timer_n    = '0;
      stage_n    = '0;
    end else begin
      case (state)
        HOLD: begin
          reset_next = '1;
          if (hold_cnt == HOLD_LAST) begin
            state_n       = WAIT_CAL;
            reset_next[0] = 1'b0;
            hold_n        = '0;
            timer_n       = '0;
          end else begin
            hold_n = hold_cnt + 1'b1;
          end
        end
        WAIT_CAL: begin
          if (cal_fail || timer == TIMEOUT_LAST) begin
            go_error = 1'b1;
          end else if (cal_success) begin
            hold_n  = '0;
            timer_n = '0;
            if (NUM_STAGES == 1) begin
              state_n    = RUN;
              reset_next = '0;
              done_next  = 1'b1;
            end else begin
              state_n = RELEASE;
              stage_n = KW'(1);
            end
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        RELEASE: begin
          if (cal_fail || !cal_success) begin
            go_error = 1'b1;
          end else if (hold_cnt == HOLD_LAST) begin
            reset_next[stage] = 1'b0;
            hold_n            = '0;
            if (stage == STAGE_LAST) begin
              state_n   = RUN;
              stage_n   = '0;
              done_next = 1'b1;
            end else begin
              stage_n = stage + 1'b1;
            end
          end else begin
            hold_n = hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (cal_fail || !cal_success) begin
            go_error = 1'b1;
          end else begin
            reset_next = '0;
            done_next  = 1'b1;
          end
        end
        ERROR: begin
          reset_next = '1;
          err_next   = 1'b1;
`ifdef RESET_SEQ_AUTO_RETRY_EN
          if (timer == TIMEOUT_LAST) begin
            state_n  = HOLD;
            err_next = 1'b0;
            timer_n  = '0;
            hold_n   = '0;
          end else begin
            timer_n = timer + 1'b1;
          end
`endif
        end
        default: begin
          state_n    = HOLD;
          reset_next = '1;
          hold_n     = '0;
          timer_n    = '0;
          stage_n    = '0;
        end
      endcase

      // Any calibration problem collapses every stage back into reset at once.
      if (go_error) begin
        state_n    = ERROR;
        reset_next = '1;
        err_next   = 1'b1;
        hold_n     = '0;
        timer_n    = '0;
        stage_n    = '0;
      end
    end
  end

endmodule

// File: tb/tb_reset_sequence_ctrl.sv
// tb/tb_reset_sequence_ctrl.sv - directed table and sequence checks for reset_sequence_ctrl
module tb_reset_sequence_ctrl;

  logic       clk;
  logic       reset;
  logic       pll_locked;
  logic       cal_success;
  logic       cal_fail;
  logic       restart_req;
  logic [3:0] reset_out;
  logic       seq_done;
  logic       seq_error;
  logic [2:0] state_o;

  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;

  reset_sequence_ctrl #(
    .NUM_STAGES    (4),
    .HOLD_CYCLES   (16),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .cal_success(cal_success),
    .cal_fail   (cal_fail),
    .restart_req(restart_req),
    .reset_out  (reset_out),
    .seq_done   (seq_done),
    .seq_error  (seq_error),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic       cs;
    logic       cf;
    logic       rr;
    logic [3:0] rst;
    logic [2:0] st;
    logic       done;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_no++;
    end
  endtask

  task automatic check(input string name, input logic [3:0] er, input logic [2:0] es,
                       input logic ed, input logic ee);
    checks++;
    if (reset_out !== er || state_o !== es || seq_done !== ed || seq_error !== ee) begin
      failures++;
      $display("FAIL %s edge=%0d got rst=%b st=%0d done=%b err=%b want rst=%b st=%0d done=%b err=%b",
               name, edge_no, reset_out, state_o, seq_done, seq_error, er, es, ed, ee);
    end
  endtask

  initial begin
    int bad;

    reset       = 1'b1;
    pll_locked  = 1'b1;
    cal_success = 1'b0;
    cal_fail    = 1'b0;
    restart_req = 1'b0;

    // absolute edge, inputs held while advancing to it, expected outputs at that edge
    tbl.push_back(vec_t'{  1, 1'b0, 1'b0, 1'b0, 4'b1111, 3'd0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{ 17, 1'b0, 1'b0, 1'b0, 4'b1111, 3'd0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{ 18, 1'b0, 1'b0, 1'b0, 4'b1110, 3'd1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{ 58, 1'b0, 1'b0, 1'b0, 4'b1110, 3'd1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{ 59, 1'b1, 1'b0, 1'b0, 4'b1110, 3'd2, 1'b0, 1'b0});
    tbl.push_back(vec_t'{ 74, 1'b1, 1'b0, 1'b0, 4'b1110, 3'd2, 1'b0, 1'b0});
    tbl.push_back(vec_t'{ 75, 1'b1, 1'b0, 1'b0, 4'b1100, 3'd2, 1'b0, 1'b0});
    tbl.push_back(vec_t'{ 90, 1'b1, 1'b0, 1'b0, 4'b1100, 3'd2, 1'b0, 1'b0});
    tbl.push_back(vec_t'{ 91, 1'b1, 1'b0, 1'b0, 4'b1000, 3'd2, 1'b0, 1'b0});
    tbl.push_back(vec_t'{106, 1'b1, 1'b0, 1'b0, 4'b1000, 3'd2, 1'b0, 1'b0});
    tbl.push_back(vec_t'{107, 1'b1, 1'b0, 1'b0, 4'b0000, 3'd3, 1'b1, 1'b0});
    tbl.push_back(vec_t'{120, 1'b1, 1'b0, 1'b0, 4'b0000, 3'd3, 1'b1, 1'b0});
    tbl.push_back(vec_t'{121, 1'b1, 1'b0, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{136, 1'b1, 1'b0, 1'b0, 4'b1111, 3'd0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{137, 1'b1, 1'b0, 1'b0, 4'b1110, 3'd1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{138, 1'b1, 1'b0, 1'b0, 4'b1110, 3'd2, 1'b0, 1'b0});
    tbl.push_back(vec_t'{154, 1'b1, 1'b0, 1'b0, 4'b1100, 3'd2, 1'b0, 1'b0});
    tbl.push_back(vec_t'{186, 1'b1, 1'b0, 1'b0, 4'b0000, 3'd3, 1'b1, 1'b0});
    tbl.push_back(vec_t'{187, 1'b1, 1'b1, 1'b0, 4'b1111, 3'd4, 1'b0, 1'b1});
    tbl.push_back(vec_t'{188, 1'b0, 1'b0, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{203, 1'b0, 1'b0, 1'b0, 4'b1111, 3'd0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{204, 1'b0, 1'b0, 1'b0, 4'b1110, 3'd1, 1'b0, 1'b0});
    tbl.push_back(vec_t'{205, 1'b1, 1'b1, 1'b0, 4'b1111, 3'd4, 1'b0, 1'b1});
    tbl.push_back(vec_t'{300, 1'b0, 1'b0, 1'b0, 4'b1111, 3'd4, 1'b0, 1'b1});

    tick(2);
    check("reset_values", 4'b1111, 3'd0, 1'b0, 1'b0);
    reset   = 1'b0;
    edge_no = 0;

    foreach (tbl[i]) begin
      cal_success = tbl[i].cs;
      cal_fail    = tbl[i].cf;
      restart_req = tbl[i].rr;
      while (edge_no < tbl[i].at) tick(1);
      check($sformatf("vec%0d", i), tbl[i].rst, tbl[i].st, tbl[i].done, tbl[i].err);
    end
    restart_req = 1'b0;

    // Calibration timeout: ERROR exactly 1024 edges after entering WAIT_CAL
    restart_req = 1'b1;
    tick(1);
    restart_req = 1'b0;
    check("to_hold", 4'b1111, 3'd0, 1'b0, 1'b0);
    tick(16);
    check("to_wait", 4'b1110, 3'd1, 1'b0, 1'b0);
    tick(1023);
    check("to_pre", 4'b1110, 3'd1, 1'b0, 1'b0);
    tick(1);
    check("to_err", 4'b1111, 3'd4, 1'b0, 1'b1);
`ifdef RESET_SEQ_AUTO_RETRY_EN
    tick(1023);
    check("retry_pre", 4'b1111, 3'd4, 1'b0, 1'b1);
    tick(1);
    check("retry_hold", 4'b1111, 3'd0, 1'b0, 1'b0);
    tick(16);
    check("retry_wait", 4'b1110, 3'd1, 1'b0, 1'b0);
`else
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      tick(1);
      if (state_o !== 3'd4 || seq_error !== 1'b1 || reset_out !== 4'b1111) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL sticky_err bad_cycles=%0d want 0", bad);
    end
`endif

    // Single-cycle lock dropout at hold count 10 restarts the hold count
    restart_req = 1'b1;
    tick(1);
    restart_req = 1'b0;
    check("glitch_hold", 4'b1111, 3'd0, 1'b0, 1'b0);
    tick(10);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    tick(16);
    check("glitch_pre", 4'b1111, 3'd0, 1'b0, 1'b0);
    tick(1);
    check("glitch_rel0", 4'b1110, 3'd1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of RELEASE
    cal_success = 1'b1;
    tick(1);
    check("mid_release", 4'b1110, 3'd2, 1'b0, 1'b0);
    tick(5);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", 4'b1111, 3'd0, 1'b0, 1'b0);
    tick(2);
    check("reset_held", 4'b1111, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(17);
    check("rerun_hold", 4'b1111, 3'd0, 1'b0, 1'b0);
    tick(1);
    check("rerun_rel0", 4'b1110, 3'd1, 1'b0, 1'b0);
    tick(1);
    check("rerun_release", 4'b1110, 3'd2, 1'b0, 1'b0);

    // Lock loss propagates through the synchronizer
    pll_locked = 1'b0;
    tick(3);
    check("lock_loss", 4'b1111, 3'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
